// File: rtl/program_loader.sv
// Purpose: receives a serial program image (count, words, XOR check byte) and
//          writes it into instruction memory, holding the core in reset until
//          a load session finishes with a matching checksum.
// Ports:   clock/reset (async active-low); start pulse; byteValid/byteReady/
//          byteData serial stream in; imemWrite* memory write port (strobe one
//          cycle after the fourth byte of each word); coreHold, loadDone,
//          loadError status levels.
module program_loader #(
  parameter int          DEPTH        = 256,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        byteValid,
  input  logic [7:0]  byteData,
  output logic        byteReady,
  output logic        imemWriteEnable,
  output logic [31:0] imemWriteAddress,
  output logic [31:0] imemWriteData,
  output logic        coreHold,
  output logic        loadDone,
  output logic        loadError
);

  typedef enum logic [2:0] {
    IDLE, COUNT_LO, COUNT_HI, DATA, CHECK, DONE, ERROR
  } state_t;

  state_t      state, nextState;
  logic [7:0]  checksum;
  logic [7:0]  countLo;
  logic [15:0] wordCount;
  logic [15:0] wordIndex;
  logic [1:0]  lane;
  logic [23:0] wordBuf;   // lanes 0..2 of the word being assembled

  logic accept;
  logic startOk;
  logic tooBig;
  logic lastWord;

  assign accept   = byteValid && byteReady;
  assign startOk  = start && (state == IDLE || state == DONE || state == ERROR);
  // Count is complete only once the high byte arrives, so compare it live.
  assign tooBig   = {16'd0, byteData, countLo} > 32'(DEPTH);
  assign lastWord = (wordIndex + 16'd1) == wordCount;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    byteReady = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) nextState = COUNT_LO;
      end
      COUNT_LO: begin
        byteReady = 1'b1;
        if (accept) nextState = COUNT_HI;
      end
      COUNT_HI: begin
        byteReady = 1'b1;
        if (accept) begin
          if (tooBig)                          nextState = ERROR;
          else if ({byteData, countLo} == 16'd0) nextState = CHECK;
          else                                 nextState = DATA;
        end
      end
      DATA: begin
        byteReady = 1'b1;
        if (accept && lane == 2'd3 && lastWord) nextState = CHECK;
      end
      CHECK: begin
        byteReady = 1'b1;
        if (accept) nextState = (byteData == checksum) ? DONE : ERROR;
      end
      default: nextState = IDLE;
    endcase
  end

  // Status levels follow the state directly so reset clears them at once.
  assign coreHold  = (state != DONE);
  assign loadDone  = (state == DONE);
  assign loadError = (state == ERROR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      imemWriteEnable  <= 1'b0;
      imemWriteAddress <= 32'd0;
      imemWriteData    <= 32'd0;
      checksum         <= 8'd0;
      countLo          <= 8'd0;
      wordCount        <= 16'd0;
      wordIndex        <= 16'd0;
      lane             <= 2'd0;
      wordBuf          <= 24'd0;
    end else begin
      imemWriteEnable <= 1'b0;
      if (startOk) begin
        checksum  <= 8'd0;
        wordIndex <= 16'd0;
        lane      <= 2'd0;
      end else if (accept) begin
        case (state)
          COUNT_LO: begin
            countLo  <= byteData;
            checksum <= checksum ^ byteData;
          end
          COUNT_HI: begin
            wordCount <= {byteData, countLo};
            checksum  <= checksum ^ byteData;
          end
          DATA: begin
            checksum <= checksum ^ byteData;
            lane     <= lane + 2'd1;
            case (lane)
              2'd0: wordBuf[7:0]   <= byteData;
              2'd1: wordBuf[15:8]  <= byteData;
              2'd2: wordBuf[23:16] <= byteData;
              default: begin
                imemWriteEnable  <= 1'b1;
                imemWriteAddress <= BASE_ADDRESS + {14'd0, wordIndex, 2'b00};
                imemWriteData    <= {byteData, wordBuf};
                wordIndex        <= wordIndex + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        byteValid = 1'b0;
  logic [7:0]  byteData = 8'h00;
  logic        byteReady;
  logic        imemWriteEnable;
  logic [31:0] imemWriteAddress;
  logic [31:0] imemWriteData;
  logic        coreHold;
  logic        loadDone;
  logic        loadError;

  program_loader #(.DEPTH(DEPTH), .BASE_ADDRESS(BASE)) dut (
    .clock(clock), .reset(reset), .start(start),
    .byteValid(byteValid), .byteData(byteData), .byteReady(byteReady),
    .imemWriteEnable(imemWriteEnable), .imemWriteAddress(imemWriteAddress),
    .imemWriteData(imemWriteData), .coreHold(coreHold),
    .loadDone(loadDone), .loadError(loadError)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0]  strm[$];     // current program stream
  logic [63:0] expQ[$];     // expected {address, data} writes, in order
  logic [63:0] capQ[$];     // writes observed in the current session
  logic        expDone, expErr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stream-level model: what a correct loader must write and conclude.
  task automatic buildModel();
    int n;
    logic [7:0] cs;
    expQ.delete();
    capQ.delete();
    expDone = 1'b0;
    expErr  = 1'b0;
    n = int'({strm[1], strm[0]});
    if (n > DEPTH) begin
      expErr = 1'b1;
      return;
    end
    cs = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) cs ^= strm[i];
    for (int w = 0; w < n; w++)
      expQ.push_back({BASE + 32'(4 * w),
                      strm[2+4*w+3], strm[2+4*w+2], strm[2+4*w+1], strm[2+4*w]});
    if (strm[2 + 4 * n] == cs) expDone = 1'b1;
    else                       expErr  = 1'b1;
  endtask

  // Per-cycle compare of the write port and status invariants.
  always @(negedge clock) begin
    if (reset) begin
      if (imemWriteEnable) begin
        capQ.push_back({imemWriteAddress, imemWriteData});
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %h@%h expected none", imemWriteData, imemWriteAddress);
        end else begin
          chk("write_addr", imemWriteAddress, expQ[0][63:32]);
          chk("write_data", imemWriteData, expQ[0][31:0]);
          void'(expQ.pop_front());
        end
      end
      chk("coreHold_vs_done", 32'(coreHold), 32'(!loadDone));
    end
  end

  task automatic doStart();
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Send strm[first..last]; gaps of 0..maxGap idle cycles before each byte.
  task automatic sendBytes(input int first, input int last, input int maxGap);
    int t;
    for (int i = first; i <= last; i++) begin
      int g;
      g = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
      if (g > 0) begin
        byteValid = 1'b0;
        repeat (g) @(posedge clock);
        #1;
      end
      byteValid = 1'b1;
      byteData  = strm[i];
      t = 0;
      forever begin
        @(negedge clock);
        t++;
        if (byteReady) begin
          @(posedge clock); #1;
          break;
        end
        if (t > 20) begin
          checks++;
          errors++;
          $display("FAIL byte_timeout: got byteReady 0 expected 1 at byte %0d", i);
          break;
        end
      end
    end
    byteValid = 1'b0;
  endtask

  task automatic endChecks(input string tag);
    repeat (2) @(posedge clock);
    #1;
    chk({tag, "_loadDone"}, 32'(loadDone), 32'(expDone));
    chk({tag, "_loadError"}, 32'(loadError), 32'(expErr));
    chk({tag, "_coreHold"}, 32'(coreHold), 32'(!expDone));
    chk({tag, "_byteReady"}, 32'(byteReady), 32'd0);
    chk({tag, "_pending_writes"}, 32'(expQ.size()), 32'd0);
  endtask

  task automatic loadStreamA(input logic [7:0] checkByte);
    strm = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, checkByte};
    buildModel();
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_byteReady"}, 32'(byteReady), 32'd0);
    chk({tag, "_we"}, 32'(imemWriteEnable), 32'd0);
    chk({tag, "_addr"}, imemWriteAddress, 32'd0);
    chk({tag, "_data"}, imemWriteData, 32'd0);
    chk({tag, "_coreHold"}, 32'(coreHold), 32'd1);
    chk({tag, "_loadDone"}, 32'(loadDone), 32'd0);
    chk({tag, "_loadError"}, 32'(loadError), 32'd0);
  endtask

  initial begin
    #1;
    checkResetOutputs("reset");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Good load: XOR of 02 00 13 00 00 00 93 00 10 00 is 0x92.
    loadStreamA(8'h92);
    doStart();
    sendBytes(0, 10, 0);
    endChecks("good");
    chk("good_writes", 32'(capQ.size()), 32'd2);
    if (capQ.size() == 2) begin
      chk("good_w0_addr", capQ[0][63:32], 32'h0000_0000);
      chk("good_w0_data", capQ[0][31:0],  32'h0000_0013);
      chk("good_w1_addr", capQ[1][63:32], 32'h0000_0004);
      chk("good_w1_data", capQ[1][31:0],  32'h0010_0093);
    end
    // Bytes offered while not ready must be ignored.
    byteValid = 1'b1;
    byteData  = 8'h55;
    repeat (3) @(posedge clock);
    #1 byteValid = 1'b0;
    chk("ignored_loadDone", 32'(loadDone), 32'd1);

    // Bad checksum: both words still written, error latched.
    loadStreamA(8'h00);
    doStart();
    sendBytes(0, 10, 0);
    endChecks("badcs");
    chk("badcs_writes", 32'(capQ.size()), 32'd2);
    chk("badcs_loadError", 32'(loadError), 32'd1);

    // Oversized count 257: error right after count, no writes.
    strm = '{8'h01, 8'h01};
    buildModel();
    doStart();
    sendBytes(0, 1, 0);
    endChecks("toobig");
    chk("toobig_writes", 32'(capQ.size()), 32'd0);

    // Empty program.
    strm = '{8'h00, 8'h00, 8'h00};
    buildModel();
    doStart();
    sendBytes(0, 2, 0);
    endChecks("empty");
    chk("empty_loadDone", 32'(loadDone), 32'd1);
    doStart();
    chk("restart_loadDone", 32'(loadDone), 32'd0);
    chk("restart_byteReady", 32'(byteReady), 32'd1);

    // Continue the restarted session with random gaps.
    loadStreamA(8'h92);
    sendBytes(0, 10, 3);
    endChecks("gaps");
    chk("gaps_writes", 32'(capQ.size()), 32'd2);
    if (capQ.size() == 2) begin
      chk("gaps_w1_addr", capQ[1][63:32], 32'h0000_0004);
      chk("gaps_w1_data", capQ[1][31:0],  32'h0010_0093);
    end

    // Reset mid-DATA right as the first strobe is pending.
    loadStreamA(8'h92);
    doStart();
    sendBytes(0, 5, 0);
    reset = 1'b0;
    #1;
    checkResetOutputs("midreset");
    expQ.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    loadStreamA(8'h92);
    doStart();
    sendBytes(0, 10, 1);
    endChecks("reload");
    chk("reload_writes", 32'(capQ.size()), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
